// File: rtl/vga_pkg.sv
// Shared types and constants for the bouncing-box pixel stage.
// Optional build macro: VGA_BOX_BORDER_EN (white frame on active-area edges).
package vga_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef enum logic {FWD, REV} dir_e;

    localparam int H_ACTIVE_C = 640;
    localparam int V_ACTIVE_C = 480;

    // red, green, blue, yellow, cyan, magenta, white, orange
    localparam rgb_t PALETTE [8] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
        12'h0FF, 12'hF0F, 12'hFFF, 12'hF80
    };

endpackage

// File: rtl/vga_bounce_box_if.sv
// Timer-to-connector bundle: sync/visible/position in, RGB and syncs out.
// slave is the pixel stage; master is the timing/source side.
interface vga_bounce_box_if;

    logic       hsync_i;
    logic       vsync_i;
    logic       visible_i;
    logic [9:0] position_x_i;
    logic [9:0] position_y_i;
    logic       vga_hsync_o;
    logic       vga_vsync_o;
    logic [3:0] vga_red_o;
    logic [3:0] vga_green_o;
    logic [3:0] vga_blue_o;

    modport slave (
        input  hsync_i, vsync_i, visible_i,
        input  position_x_i, position_y_i,
        output vga_hsync_o, vga_vsync_o,
        output vga_red_o, vga_green_o, vga_blue_o
    );

    modport master (
        output hsync_i, vsync_i, visible_i,
        output position_x_i, position_y_i,
        input  vga_hsync_o, vga_vsync_o,
        input  vga_red_o, vga_green_o, vga_blue_o
    );

endinterface

// File: rtl/bounce_axis.sv
// One axis of box motion: saturating step toward a wall, then reverse.
// bounce_o is combinational and only valid in the event cycle.
module bounce_axis
    import vga_pkg::*;
#(
    parameter int ACTIVE   = 640,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        event_i,
    input  logic        pause_i,
    output logic [10:0] pos_o,
    output logic        bounce_o
);

    localparam logic [10:0] LIM    = 11'(ACTIVE - BOX_SIZE);
    localparam logic [10:0] STEP_C = 11'(STEP);

    dir_e        state_q, state_d;
    logic [10:0] pos_q, pos_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FWD;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        bounce_o = 1'b0;
        if (event_i && !pause_i) begin
            unique case (state_q)
                FWD: begin
                    if (pos_q + STEP_C > LIM) begin
                        pos_d    = LIM;
                        state_d  = REV;
                        bounce_o = 1'b1;
                    end else begin
                        pos_d = pos_q + STEP_C;
                    end
                end
                REV: begin
                    if (pos_q < STEP_C) begin
                        pos_d    = '0;
                        state_d  = FWD;
                        bounce_o = 1'b1;
                    end else begin
                        pos_d = pos_q - STEP_C;
                    end
                end
                default: state_d = FWD;
            endcase
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/vga_bounce_box.sv
// Two-stage pixel generator drawing a bouncing, colour-cycling square.
// Build with VGA_BOX_BORDER_EN to add a white active-area border.
module vga_bounce_box
    import vga_pkg::*;
#(
    parameter int          H_ACTIVE = H_ACTIVE_C,
    parameter int          V_ACTIVE = V_ACTIVE_C,
    parameter int          BOX_SIZE = 32,
    parameter int          STEP     = 1,
    parameter logic [11:0] BG_RGB   = 12'h000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pause_i,
    vga_bounce_box_if.slave vga,
    output logic            frame_tick_o
);

    localparam logic [10:0] BOX_C = 11'(BOX_SIZE);

    logic        evt;
    logic [10:0] px, py;
    logic [10:0] box_x, box_y;
    logic        bnc_x, bnc_y;
    logic [2:0]  ci_q;

    assign px  = {1'b0, vga.position_x_i};
    assign py  = {1'b0, vga.position_y_i};
    // first blanking line start: box moves while nothing is displayed
    assign evt = (px == 11'd0) && (py == 11'(V_ACTIVE));

    bounce_axis #(
        .ACTIVE(H_ACTIVE), .BOX_SIZE(BOX_SIZE), .STEP(STEP)
    ) u_axis_x (
        .clk_i, .rst_i, .event_i(evt), .pause_i,
        .pos_o(box_x), .bounce_o(bnc_x)
    );

    bounce_axis #(
        .ACTIVE(V_ACTIVE), .BOX_SIZE(BOX_SIZE), .STEP(STEP)
    ) u_axis_y (
        .clk_i, .rst_i, .event_i(evt), .pause_i,
        .pos_o(box_y), .bounce_o(bnc_y)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_tick_o <= 1'b0;
            ci_q         <= '0;
        end else begin
            frame_tick_o <= evt;
            if (bnc_x || bnc_y) ci_q <= ci_q + 3'd1;
        end
    end

    logic hs1, vs1, vis1, in1, edge1;
    logic in_x, in_y, edge_d;

    assign in_x = (px >= box_x) && (px < box_x + BOX_C);
    assign in_y = (py >= box_y) && (py < box_y + BOX_C);

`ifdef VGA_BOX_BORDER_EN
    assign edge_d = (px == 11'd0) || (px == 11'(H_ACTIVE - 1))
                 || (py == 11'd0) || (py == 11'(V_ACTIVE - 1));
`else
    assign edge_d = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hs1   <= 1'b1;
            vs1   <= 1'b1;
            vis1  <= 1'b0;
            in1   <= 1'b0;
            edge1 <= 1'b0;
        end else begin
            hs1   <= vga.hsync_i;
            vs1   <= vga.vsync_i;
            vis1  <= vga.visible_i;
            in1   <= in_x && in_y;
            edge1 <= edge_d;
        end
    end

    rgb_t rgb_d, rgb_q;
    logic hs2, vs2;

    always_comb begin
        rgb_d = '0;
        if (vis1) begin
            if (in1) rgb_d = PALETTE[ci_q];
            else     rgb_d = BG_RGB;
            if (edge1) rgb_d = 12'hFFF;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hs2   <= 1'b1;
            vs2   <= 1'b1;
            rgb_q <= '0;
        end else begin
            hs2   <= hs1;
            vs2   <= vs1;
            rgb_q <= rgb_d;
        end
    end

    assign vga.vga_hsync_o = hs2;
    assign vga.vga_vsync_o = vs2;
    assign vga.vga_red_o   = rgb_q.r;
    assign vga.vga_green_o = rgb_q.g;
    assign vga.vga_blue_o  = rgb_q.b;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Scoreboard bench for vga_bounce_box: random pixels checked against a
// plain-arithmetic model of the bouncing square.
module tb_vga_bounce_box;

    localparam int          STEP = 8;
    localparam int          BOX  = 32;
    localparam int          HA   = 640;
    localparam int          VA   = 480;
    localparam logic [11:0] BG   = 12'h000;
    localparam logic [11:0] PAL [8] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
        12'h0FF, 12'hF0F, 12'hFFF, 12'hF80
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pause = 1'b0;
    logic tick;

    always #20 clk = ~clk;

    vga_bounce_box_if vif ();

    vga_bounce_box #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .BOX_SIZE(BOX),
        .STEP(STEP), .BG_RGB(BG)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .pause_i(pause),
        .vga(vif),
        .frame_tick_o(tick)
    );

    typedef struct {
        int          due;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    exp_t q[$];
    int   tq[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   armed = 0;

    // reference state: box corner, direction (1 = moving back), colour
    int bx, by, ci;
    bit rx, ry;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] model_pix(int x, int y, bit vis);
        logic [11:0] c;
        if (!vis) return 12'h000;
        if (x >= bx && x < bx + BOX && y >= by && y < by + BOX) c = PAL[ci];
        else c = BG;
`ifdef VGA_BOX_BORDER_EN
        if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) c = 12'hFFF;
`endif
        return c;
    endfunction

    task automatic axis_move(inout int p, inout bit rev, input int lim,
                             output bit hit);
        int np;
        np  = rev ? p - STEP : p + STEP;
        hit = 0;
        if (np > lim) begin np = lim; hit = 1; end
        else if (np < 0) begin np = 0; hit = 1; end
        if (hit) rev = ~rev;
        p = np;
    endtask

    task automatic model_event();
        bit hx, hy;
        axis_move(bx, rx, HA - BOX, hx);
        axis_move(by, ry, VA - BOX, hy);
        if (hx || hy) ci = (ci + 1) % 8;
    endtask

    task automatic model_reset();
        bx = 0; by = 0; rx = 0; ry = 0; ci = 0;
    endtask

    task automatic drive(int x, int y, bit vis, bit hs, bit vs);
        exp_t e;
        @(posedge clk);
        #1;
        vif.position_x_i = 10'(x);
        vif.position_y_i = 10'(y);
        vif.visible_i    = vis;
        vif.hsync_i      = hs;
        vif.vsync_i      = vs;
        e.due = cyc + 2;
        e.hs  = hs;
        e.vs  = vs;
        e.rgb = model_pix(x, y, vis);
        q.push_back(e);
        if (x == 0 && y == VA) begin
            tq.push_back(cyc + 1);
            if (!pause) model_event();
        end
    endtask

    task automatic probe(int x, int y);
        bit vis;
        if (x < 0) x = 0;
        if (x == 0 && y == VA) y = VA + 1;
        vis = (x < HA) && (y < VA);
        if ($urandom_range(0, 7) == 0) vis = 0;
        drive(x, y, vis, 1'($urandom), 1'($urandom));
    endtask

    task automatic rand_probe();
        int x, y;
        if ($urandom_range(0, 1) == 0) begin
            x = bx + int'($urandom_range(0, BOX + 1)) - 1;
            y = by + int'($urandom_range(0, BOX + 1)) - 1;
            if (y < 0) y = 0;
        end else begin
            x = $urandom_range(0, 799);
            y = $urandom_range(0, 524);
        end
        probe(x, y);
    endtask

    task automatic tick_frame(int nrand);
        drive(0, VA, 0, 1'($urandom), 1'b0);
        probe(bx, by);
        probe(bx + BOX - 1, by + BOX - 1);
        probe(bx + BOX, by);
        probe(bx, by + BOX);
        probe(bx - 1, by);
        for (int i = 0; i < nrand; i++) rand_probe();
    endtask

    task automatic apply_reset();
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b1;
        vif.position_x_i = 10'd320;
        vif.position_y_i = 10'd240;
        vif.visible_i    = 1'b1;
        vif.hsync_i      = 1'b0;
        vif.vsync_i      = 1'b0;
        q.delete();
        tq.delete();
        model_reset();
        e.hs = 1'b1; e.vs = 1'b1; e.rgb = 12'h000;
        e.due = cyc + 1; q.push_back(e);
        e.due = cyc + 2; q.push_back(e);
        armed = 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        e.due = cyc + 2;
        e.hs  = 1'b0;
        e.vs  = 1'b0;
        e.rgb = model_pix(320, 240, 1);
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [11:0] got;
        bit exp_tick;
        if (armed) begin
            while (tq.size() > 0 && tq[0] < cyc) begin
                void'(tq.pop_front());
                miscompares++;
                $display("FAIL tick_order cyc=%0d: stale tick entry", cyc);
            end
            exp_tick = (tq.size() > 0 && tq[0] == cyc);
            if (exp_tick) void'(tq.pop_front());
            vectors++;
            if (tick !== exp_tick) begin
                miscompares++;
                $display("FAIL frame_tick cyc=%0d: got %b want %b",
                         cyc, tick, exp_tick);
            end
            while (q.size() > 0 && q[0].due < cyc) begin
                e = q.pop_front();
                miscompares++;
                $display("FAIL pixel_order cyc=%0d: missed due %0d", cyc, e.due);
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                got = {vif.vga_red_o, vif.vga_green_o, vif.vga_blue_o};
                vectors++;
                if (vif.vga_hsync_o !== e.hs || vif.vga_vsync_o !== e.vs ||
                    got !== e.rgb) begin
                    miscompares++;
                    $display("FAIL pixel cyc=%0d: got hs=%b vs=%b rgb=%h want hs=%b vs=%b rgb=%h",
                             cyc, vif.vga_hsync_o, vif.vga_vsync_o, got,
                             e.hs, e.vs, e.rgb);
                end
            end
        end
    end

    initial begin
        vif.position_x_i = '0;
        vif.position_y_i = '0;
        vif.visible_i    = 1'b0;
        vif.hsync_i      = 1'b1;
        vif.vsync_i      = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        apply_reset();

        // first frame: box at origin in red
        probe(0, 0);
        probe(32, 0);
        probe(31, 31);
        probe(0, 32);
        for (int i = 0; i < 6; i++) rand_probe();

        // free run up to the first corner hit (x every 77, y every 57 events)
        for (int t = 0; t < 77 * 57; t++) tick_frame(0);
        tick_frame(4);

        // frozen motion across three events
        pause = 1'b1;
        for (int t = 0; t < 3; t++) tick_frame(2);
        pause = 1'b0;

        for (int t = 0; t < 150; t++) begin
            pause = ($urandom_range(0, 3) == 0);
            tick_frame(2);
        end
        pause = 1'b0;

        // reset in the middle of the visible area
        for (int x = 316; x < 320; x++) probe(x, 240);
        apply_reset();
        probe(0, 0);
        probe(31, 31);
        probe(32, 0);
        for (int t = 0; t < 3; t++) tick_frame(2);

        repeat (4) @(posedge clk);
        if (q.size() != 0 || tq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d pixel and %0d tick checks left, want 0",
                     q.size(), tq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
